systolic_sequencer: RTL and testbench

// - Sequences one N x N grid of Element PEs through a matrix multiply: C = A(NxK) * B(KxN).
// - Clears the PE accumulators, then fetches one column of A and one row of B per cycle

---
 rtl/systolic_sequencer_pkg.sv | 26 ++
 rtl/systolic_sequencer_skew_line.sv | 47 ++++
 rtl/systolic_sequencer.sv | 143 ++++++++++++++
 tb/tb_systolic_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic sequencer:
//   state_t   - sequencer FSM states
//   DEFAULT_W - default operand width (matches the Element a_in/b_in width)
//   last_cnt  - final RUN count value for an N x N grid with inner dimension K
// -----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEFAULT_W = 8;

   // The last operand pair reaches PE(N-1,N-1) at count K+2N-2 (lane skew of
   // N-1 plus N-1 forwarding stages plus the one-cycle fetch latency); its
   // c_out is registered one cycle later, which is the final RUN count.
   function automatic int last_cnt(input int n, input int k);
      return k + 2 * n - 1;
   endfunction

endpackage

// File: rtl/systolic_sequencer_skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// DEPTH-stage register delay used to stagger one operand lane into the grid.
// DEPTH = 0 degenerates to a plain wire.
// Ports:
//   i_clock  in  1  system clock, rising edge
//   i_clear  in  1  synchronous clear of every stage (active high)
//   i_data   in  W  lane data entering the delay
//   o_data   out W  lane data delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module skew_line #(
   parameter int W     = 8,
   parameter int DEPTH = 1
) (
   input  logic         i_clock,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data
);

   generate
      if (DEPTH == 0) begin : g_wire
         // No stages: clock and clear are intentionally left without effect.
         logic w_unused_ctrl;
         assign w_unused_ctrl = i_clock ^ i_clear;
         assign o_data        = i_data;
      end else begin : g_regs
         logic [W-1:0] r_stage [DEPTH];

         always_ff @(posedge i_clock) begin
            if (i_clear) begin
               for (int s = 0; s < DEPTH; s++) begin
                  r_stage[s] <= '0;
               end
            end else begin
               r_stage[0] <= i_data;
               for (int s = 1; s < DEPTH; s++) begin
                  r_stage[s] <= r_stage[s-1];
               end
            end
         end

         assign o_data = r_stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Runs one N x N grid of Element PEs through C = A(NxK) * B(KxN): clears the
// accumulators, streams one column of A and one row of B per cycle out of the
// operand buffers, skews them onto the west/north edge lanes and pulses done
// once every PE c_out holds its final dot product.
// Ports:
//   i_clock        in  1    system clock, rising edge
//   i_reset        in  1    synchronous reset, active high
//   i_start        in  1    begin a run (only looked at in IDLE)
//   o_busy         out 1    high in CLEAR and RUN
//   o_done         out 1    one-cycle pulse, all c_out values final
//   o_mem_rd       out 1    operand buffer read strobe
//   o_mem_addr     out CK   beat index k
//   i_mem_a_col    in  N*W  A[i][k] on lane i, valid one cycle after o_mem_rd
//   i_mem_b_row    in  N*W  B[k][j] on lane j, same timing
//   o_a_lane       out N*W  west edge lanes, lane i -> PE(i,0).a_in
//   o_b_lane       out N*W  north edge lanes, lane j -> PE(0,j).b_in
//   o_array_clear  out 1    reset for every Element
// -----------------------------------------------------------------------------
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int K  = 4,
   parameter  int W  = DEFAULT_W,
   localparam int CK = (K > 1) ? $clog2(K) : 1
) (
   input  logic           i_clock,
   input  logic           i_reset,
   input  logic           i_start,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_mem_rd,
   output logic [CK-1:0]  o_mem_addr,
   input  logic [N*W-1:0] i_mem_a_col,
   input  logic [N*W-1:0] i_mem_b_row,
   output logic [N*W-1:0] o_a_lane,
   output logic [N*W-1:0] o_b_lane,
   output logic           o_array_clear
);

   localparam int            LAST     = last_cnt(N, K);
   localparam int            CW       = $clog2(K + 2 * N);
   localparam logic [CW-1:0] LAST_CNT = CW'(LAST);
   localparam logic [CW-1:0] K_CNT    = CW'(K);

   state_t         r_state;
   state_t         w_state_next;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_next;
   logic           r_array_clear;
   logic           r_rd_valid;
   logic           w_mem_rd;
   logic [N*W-1:0] w_a_gated;
   logic [N*W-1:0] w_b_gated;

   // ---------------------------------------------------------------- state
   // array_clear is registered so it stays high for the cycle that follows a
   // reset edge (including a reset issued mid-run) as well as in CLEAR.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_array_clear <= 1'b1;
         r_rd_valid    <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_array_clear <= (w_state_next == CLEAR);
         r_rd_valid    <= w_mem_rd;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_next = CLEAR;
            end
         end
         CLEAR: begin
            w_cnt_next   = '0;
            w_state_next = RUN;
         end
         RUN: begin
            if (r_cnt == LAST_CNT) begin
               w_state_next = DONE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign w_mem_rd      = (r_state == RUN) && (r_cnt < K_CNT);
   assign o_mem_rd      = w_mem_rd;
   assign o_mem_addr    = w_mem_rd ? r_cnt[CK-1:0] : '0;
   assign o_busy        = (r_state == CLEAR) || (r_state == RUN);
   assign o_done        = (r_state == DONE);
   assign o_array_clear = r_array_clear;

   // ---------------------------------------------------------------- skew
   // Buffer data is only trusted in the cycle after a read we issued; anything
   // else is replaced by zeros, which leave the accumulators untouched.
   assign w_a_gated = r_rd_valid ? i_mem_a_col : '0;
   assign w_b_gated = r_rd_valid ? i_mem_b_row : '0;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         skew_line #(
            .W     (W),
            .DEPTH (gi)
         ) u_skew_a (
            .i_clock (i_clock),
            .i_clear (i_reset),
            .i_data  (w_a_gated[gi*W +: W]),
            .o_data  (o_a_lane[gi*W +: W])
         );

         skew_line #(
            .W     (W),
            .DEPTH (gi)
         ) u_skew_b (
            .i_clock (i_clock),
            .i_clear (i_reset),
            .i_data  (w_b_gated[gi*W +: W]),
            .o_data  (o_b_lane[gi*W +: W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_systolic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_sequencer
// Two sequencers (N=2,K=2 and N=4,K=1), each driving a behavioural Element
// grid and fed by a one-cycle-latency operand ROM that returns random junk
// whenever no read was issued. Expected products and lane contents are derived
// directly from the matrices.
// -----------------------------------------------------------------------------
module tb_systolic_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------- DUT 0 (N=2,K=2)
   logic        st2, rs2, busy2, done2, rd2, ac2;
   logic [0:0]  addr2;
   logic [15:0] a_col2, b_row2, a_lane2, b_lane2;

   systolic_sequencer #(.N(2), .K(2), .W(8)) u_dut2 (
      .i_clock       (clk),
      .i_reset       (rs2),
      .i_start       (st2),
      .o_busy        (busy2),
      .o_done        (done2),
      .o_mem_rd      (rd2),
      .o_mem_addr    (addr2),
      .i_mem_a_col   (a_col2),
      .i_mem_b_row   (b_row2),
      .o_a_lane      (a_lane2),
      .o_b_lane      (b_lane2),
      .o_array_clear (ac2)
   );

   // ---------------------------------------------------------------- DUT 1 (N=4,K=1)
   logic        st4, rs4, busy4, done4, rd4, ac4;
   logic [0:0]  addr4;
   logic [31:0] a_col4, b_row4, a_lane4, b_lane4;

   systolic_sequencer #(.N(4), .K(1), .W(8)) u_dut4 (
      .i_clock       (clk),
      .i_reset       (rs4),
      .i_start       (st4),
      .o_busy        (busy4),
      .o_done        (done4),
      .o_mem_rd      (rd4),
      .o_mem_addr    (addr4),
      .i_mem_a_col   (a_col4),
      .i_mem_b_row   (b_row4),
      .o_a_lane      (a_lane4),
      .o_b_lane      (b_lane4),
      .o_array_clear (ac4)
   );

   // ---------------------------------------------------------------- per-instance views
   logic        ob_busy [2];
   logic        ob_done [2];
   logic        ob_rd   [2];
   logic        ob_ac   [2];
   logic [31:0] ob_addr [2];
   logic [7:0]  la  [2][4];
   logic [7:0]  lb  [2][4];
   logic [7:0]  ain [2][4][4];
   logic [7:0]  bin [2][4][4];
   logic [7:0]  pa  [2][4][4];   // Element a forwarding register
   logic [7:0]  pb  [2][4][4];   // Element b forwarding register
   logic [7:0]  pc  [2][4][4];   // Element accumulator (c_out)
   logic [7:0]  ma  [2][4][4];   // A[u][i][k]
   logic [7:0]  mb  [2][4][4];   // B[u][k][j]

   always_comb begin
      ob_busy[0] = busy2;  ob_busy[1] = busy4;
      ob_done[0] = done2;  ob_done[1] = done4;
      ob_rd[0]   = rd2;    ob_rd[1]   = rd4;
      ob_ac[0]   = ac2;    ob_ac[1]   = ac4;
      ob_addr[0] = 32'(addr2);
      ob_addr[1] = 32'(addr4);
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 4; i++) begin
            la[u][i] = '0;
            lb[u][i] = '0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         la[0][i] = a_lane2[i*8 +: 8];
         lb[0][i] = b_lane2[i*8 +: 8];
      end
      for (int i = 0; i < 4; i++) begin
         la[1][i] = a_lane4[i*8 +: 8];
         lb[1][i] = b_lane4[i*8 +: 8];
      end
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               if (j == 0) ain[u][i][j] = la[u][i];
               else        ain[u][i][j] = pa[u][i][j-1];
               if (i == 0) bin[u][i][j] = lb[u][j];
               else        bin[u][i][j] = pb[u][i-1][j];
            end
         end
      end
   end

   // Element grid: forward a east and b south, accumulate a*b modulo 2^8.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               if (ob_ac[u]) begin
                  pa[u][i][j] <= '0;
                  pb[u][i][j] <= '0;
                  pc[u][i][j] <= '0;
               end else begin
                  pa[u][i][j] <= ain[u][i][j];
                  pb[u][i][j] <= bin[u][i][j];
                  pc[u][i][j] <= pc[u][i][j] + ain[u][i][j] * bin[u][i][j];
               end
            end
         end
      end
   end

   // Operand ROM, one cycle latency; junk when no read is issued.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         a_col2[i*8 +: 8] <= rd2 ? ma[0][i][addr2] : 8'($urandom);
         b_row2[i*8 +: 8] <= rd2 ? mb[0][addr2][i] : 8'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         a_col4[i*8 +: 8] <= rd4 ? ma[1][i][addr4] : 8'($urandom);
         b_row4[i*8 +: 8] <= rd4 ? mb[1][addr4][i] : 8'($urandom);
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ndim(input int u);
      return (u == 0) ? 2 : 4;
   endfunction

   function automatic int kdim(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic logic [7:0] ref_c(input int u, input int i, input int j);
      logic [7:0] acc = '0;
      for (int k = 0; k < kdim(u); k++) acc = acc + ma[u][i][k] * mb[u][k][j];
      return acc;
   endfunction

   task automatic set_start(input int u, input logic v);
      if (u == 0) st2 = v; else st4 = v;
   endtask

   task automatic set_rst(input int u, input logic v);
      if (u == 0) rs2 = v; else rs4 = v;
   endtask

   // fixed: u=0 -> A=[[1,2],[3,4]], B=[[5,6],[7,8]]; u=1 -> A col 1..4, B row 5..8
   task automatic load_mats(input int u, input bit fixed);
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (fixed && u == 0) begin
               ma[u][i][k] = 8'(2 * i + k + 1);
               mb[u][k][i] = 8'(5 + 2 * k + i);
            end else if (fixed) begin
               ma[u][i][k] = 8'(i + 1);
               mb[u][k][i] = 8'(i + 5);
            end else begin
               ma[u][i][k] = 8'($urandom);
               mb[u][k][i] = 8'($urandom);
            end
         end
      end
   endtask

   // One full run. Observations are taken at negedges; observation s=0 is the
   // CLEAR cycle, s=1..LAST+1 are RUN counts 0..LAST, done expected at LAST+2,
   // i.e. K+2N+1 clock edges after the edge that sampled start.
   task automatic do_run(input int u, input bit hold, input bit poke, input bit lanes);
      int n, k, last, s_done, cnt, kk;
      logic [7:0] ea, eb;
      n = ndim(u); k = kdim(u); last = k + 2 * n - 1;
      set_start(u, 1'b1);
      @(negedge clk);
      if (!hold) set_start(u, 1'b0);
      chk("clear_ac", 32'(ob_ac[u]), 1);
      chk("clear_busy", 32'(ob_busy[u]), 1);
      s_done = -1;
      for (int s = 1; s <= last + 6 && s_done < 0; s++) begin
         @(negedge clk);
         if (ob_done[u]) begin
            s_done = s;
         end else if (s <= last + 1) begin
            cnt = s - 1;
            chk("run_busy", 32'(ob_busy[u]), 1);
            chk("mem_rd", 32'(ob_rd[u]), (cnt < k) ? 1 : 0);
            chk("mem_addr", ob_addr[u], (cnt < k) ? 32'(cnt) : 0);
            if (lanes) begin
               for (int i = 0; i < n; i++) begin
                  kk = cnt - 1 - i;
                  ea = (kk >= 0 && kk < k) ? ma[u][i][kk] : 8'd0;
                  eb = (kk >= 0 && kk < k) ? mb[u][kk][i] : 8'd0;
                  chk("a_lane", 32'(la[u][i]), 32'(ea));
                  chk("b_lane", 32'(lb[u][i]), 32'(eb));
               end
            end
            if (poke) set_start(u, 1'($urandom_range(0, 1)));
         end
      end
      if (s_done < 0) begin
         chk("done_seen", 0, 1);
      end else begin
         chk("latency", 32'(s_done), 32'(k + 2 * n + 1));
         chk("done_busy", 32'(ob_busy[u]), 0);
         for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
               chk("c_out", 32'(pc[u][i][j]), 32'(ref_c(u, i, j)));
         if (poke) set_start(u, 1'b1);
         @(negedge clk);
         chk("done_pulse", 32'(ob_done[u]), 0);
         if (!hold) begin
            set_start(u, 1'b0);
            @(negedge clk);
            chk("idle_stay", 32'(ob_busy[u]), 0);
         end
      end
      $display("run u=%0d n=%0d k=%0d hold=%0d poke=%0d lat=%0d c00=%0d", u, n, k, hold, poke,
               s_done, pc[u][0][0]);
   endtask

   // Start a run, reset it at RUN count `at`, confirm it is abandoned.
   task automatic do_reset_mid(input int u, input int at);
      int n, last;
      logic seen;
      n = ndim(u); last = kdim(u) + 2 * n - 1;
      set_start(u, 1'b1);
      @(negedge clk);
      set_start(u, 1'b0);
      for (int s = 1; s <= at + 1; s++) @(negedge clk);
      set_rst(u, 1'b1);
      @(negedge clk);
      set_rst(u, 1'b0);
      chk("rst_busy", 32'(ob_busy[u]), 0);
      chk("rst_done", 32'(ob_done[u]), 0);
      chk("rst_ac", 32'(ob_ac[u]), 1);
      chk("rst_rd", 32'(ob_rd[u]), 0);
      for (int i = 0; i < n; i++) begin
         chk("rst_a_lane", 32'(la[u][i]), 0);
         chk("rst_b_lane", 32'(lb[u][i]), 0);
      end
      seen = 1'b0;
      for (int s = 0; s < last + 4; s++) begin
         @(negedge clk);
         if (ob_done[u]) seen = 1'b1;
      end
      chk("rst_no_done", 32'(seen), 0);
      $display("reset-mid u=%0d at_cnt=%0d done_seen=%0d", u, at, seen);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      st2 = 1'b0; st4 = 1'b0;
      rs2 = 1'b1; rs4 = 1'b1;
      load_mats(0, 1'b1);
      load_mats(1, 1'b1);
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rs_busy", 32'(ob_busy[u]), 0);
         chk("rs_done", 32'(ob_done[u]), 0);
         chk("rs_rd", 32'(ob_rd[u]), 0);
         chk("rs_addr", ob_addr[u], 0);
         chk("rs_ac", 32'(ob_ac[u]), 1);
         for (int i = 0; i < ndim(u); i++) begin
            chk("rs_a_lane", 32'(la[u][i]), 0);
            chk("rs_b_lane", 32'(lb[u][i]), 0);
         end
      end
      $display("reset held: checked both instances");
      rs2 = 1'b0; rs4 = 1'b0;
      @(negedge clk);
      chk("idle_ac0", 32'(ob_ac[0]), 0);
      chk("idle_ac1", 32'(ob_ac[1]), 0);

      // 2x2 known product with lane timing
      load_mats(0, 1'b1);
      do_run(0, 1'b0, 1'b0, 1'b1);

      // back-to-back with start held, second product must not accumulate
      load_mats(0, 1'b0);
      do_run(0, 1'b1, 1'b0, 1'b1);
      load_mats(0, 1'b0);
      do_run(0, 1'b0, 1'b0, 1'b1);

      // start noise during RUN and DONE
      load_mats(0, 1'b0);
      do_run(0, 1'b0, 1'b1, 1'b1);

      // reset at count 3, then a clean run
      load_mats(0, 1'b0);
      do_reset_mid(0, 3);
      load_mats(0, 1'b0);
      do_run(0, 1'b0, 1'b0, 1'b1);

      // N=4, K=1 known product
      load_mats(1, 1'b1);
      do_run(1, 1'b0, 1'b0, 1'b1);

      // random runs on both instances
      for (int r = 0; r < 8; r++) begin
         load_mats(r % 2, 1'b0);
         do_run(r % 2, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      end
      load_mats(1, 1'b0);
      do_reset_mid(1, 2);
      load_mats(1, 1'b0);
      do_run(1, 1'b0, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
